sdram_pmem_arb: RTL and testbench
=================================

// Module: sdram_pmem_arb
// PURPOSE
//  Two-port round-robin arbiter that shares one SDRAM ram_* request interface between two pmem-style requesters.
//  Port 0 is typically the instruction pmem and port 1 the data pmem.
//  Locks the grant for the full length of a burst and tracks outstanding beats in an ID FIFO.
//  Routes each ram_ack_i, with its read data and error, back to the requester that issued the beat (in-order).
// PARAMETERS
//  OUTSTANDING  4  max beats accepted by the SDRAM but not yet acked (tracking FIFO depth; power of 2)
//  OUT_W        2  log2(OUTSTANDING)
// PORTS
//  clk               in   1   clock; single clock domain
//  rst               in   1   synchronous reset, active-high
//  p0_wr_i           in   4   port0 write byte strobes (non-zero = write beat)
//  p0_rd_i           in   1   port0 read beat request
//  p0_len_i          in   8   port0 burst beats-1, sampled on first beat of a burst
//  p0_addr_i         in   32  port0 byte address
//  p0_write_data_i   in   32  port0 write data
//  p0_accept_o       out  1   port0 beat accepted this cycle
//  p0_ack_o          out  1   port0 beat completed
//  p0_error_o        out  1   port0 completion error (valid with p0_ack_o)
//  p0_read_data_o    out  32  port0 read data (valid with p0_ack_o)
//  p1_*              -    -   identical set for port1
//  ram_wr_o          out  4   to SDRAM core: write strobes of granted port
//  ram_rd_o          out  1   to SDRAM core: read of granted port
//  ram_len_o         out  8   to SDRAM core: granted port len
//  ram_addr_o        out  32  to SDRAM core: granted port address
//  ram_write_data_o  out  32  to SDRAM core: granted port write data
//  ram_accept_i      in   1   SDRAM core accepts current beat
//  ram_ack_i         in   1   SDRAM core completes one beat (reads and writes)
//  ram_error_i       in   1   error qualifier for ram_ack_i
//  ram_read_data_i   in   32  read data qualifier for ram_ack_i
// BEHAVIOUR
//  Request: pN_req = (|pN_wr_i) | pN_rd_i. Requesters hold request and payload stable until pN_accept_o.
//  FSM states:
//   IDLE
//    - Grant is combinational, with zero-cycle pass-through.
//    - Only one port requesting -> that port wins.
//    - Both ports requesting -> the port != last_q wins.
//   BURST
//    - Grant is fixed to lock_q; the other port is ignored.
//  Transitions:
//   - IDLE -> BURST: on an accepted beat with ram_len_o != 0.
//     lock_q <= winner; beats_q <= ram_len_o; last_q <= winner.
//   - IDLE, accepted beat with len == 0: stays IDLE; last_q <= winner.
//   - BURST: each accepted beat decrements beats_q.
//   - BURST -> IDLE: on the accepted beat when beats_q == 1.
//  Outputs:
//   - ram_* outputs mirror the granted port.
//   - With no grant, ram_wr_o = 0, ram_rd_o = 0, and other ram_* outputs = 0.
//  ID FIFO not full gates every grant: when count == OUTSTANDING, ram_wr_o, ram_rd_o and both accepts = 0. A same-cycle pop does not bypass this gate.
//  pN_accept_o = granted(N) & ram_accept_i & fifo_not_full; the non-granted accept is 0.
//  Tracking on accepted beat (ram_accept_i & (|ram_wr_o | ram_rd_o)):
//   - Pushes the granted port ID (1 bit) into the ID FIFO.
//   - Push and pop in the same cycle: count unchanged.
//  Completion on ram_ack_i:
//   - Pops the FIFO head h; asserts ph_ack_o the same cycle (combinational, 0 latency).
//   - ph_read_data_o = ram_read_data_i; ph_error_o = ram_error_i.
//   - The other port's ack/error = 0.
//   - Read data is driven to both ports; qualify with ack.
//  ram_ack_i with an empty FIFO: no ack is generated; the FIFO is unchanged; illegal (bench assertion).
//  Port asserting both wr and rd: treated as a write; rd is ignored for that beat.
//  Reset (any cycle, incl. mid-burst):
//   - State <= IDLE; last_q <= 1 (port0 wins the first contention); beats_q <= 0.
//   - FIFO count/pointers <= 0.
//   - All outputs 0 in the reset cycle and after while no requests/acks are present.
//   - Acks for beats issued before reset are dropped.
//  Widths: beats_q is 8 bits; len 255 = 256 beats; no wrap beyond 0.
// TESTING
//  1. Reset, then p0_rd_i=1, len=0, addr=0x100, ram_accept_i=1.
//     -> ram_rd_o=1 and ram_addr_o=0x100 the same cycle; p0_accept_o=1.
//     -> ram_ack_i 3 cycles later with data 0xDEADBEEF -> p0_ack_o=1, p0_read_data_o=0xDEADBEEF, p1_ack_o=0.
//  2. Both ports request single beats every cycle after reset, ram_accept_i=1, acks keeping pace.
//     -> grants alternate 0,1,0,1; each ack returns to the issuing port in order.
//  3. p1 write burst len=3 while p0 reads continuously.
//     -> 4 consecutive p1 beats (wstrb=0xF) before any p0 grant; p0 is granted the next cycle.
//  4. ram_ack_i held 0 with both ports requesting, OUTSTANDING=4.
//     -> exactly 4 beats accepted, then accepts=0 until one ack; the 5th beat is accepted in the cycle after the ack.
//  5. ram_accept_i=0 for 5 cycles mid-burst (p0 len=7).
//     -> grant stays on p0, beats_q frozen; the burst completes with 8 total accepts and no p1 interleave.
//  6. rst=1 during the 3rd beat of a len=7 burst.
//     -> the next cycle is IDLE with FIFO empty; p1 wins a contention with p0? no: p0 wins (last_q=1); a stale ram_ack_i produces no pN_ack_o.

Source files
------------

// File: rtl/sdram_pmem_arb.sv
// rtl/sdram_pmem_arb.sv - two-port round-robin arbiter sharing one SDRAM request interface
//
// Purpose:
//   Shares a single SDRAM ram_* request interface between two pmem-style
//   requesters (port 0 typically instruction fetch, port 1 data). The grant is
//   round-robin between single beats and is locked for the full length of a
//   burst. Every accepted beat pushes the issuing port ID into a small in-order
//   tracking FIFO; each ram_ack_i pops that FIFO and steers the completion
//   (ack, error, read data) back to the issuing port with zero latency.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   pN_wr_i             port N write byte strobes (non-zero = write beat)
//   pN_rd_i             port N read beat request
//   pN_len_i            port N burst beats-1, taken on the first beat of a burst
//   pN_addr_i           port N byte address
//   pN_write_data_i     port N write data
//   pN_accept_o         port N beat accepted this cycle
//   pN_ack_o            port N beat completed
//   pN_error_o          port N completion error, valid with pN_ack_o
//   pN_read_data_o      port N read data, valid with pN_ack_o
//   ram_wr_o/rd_o       write strobes / read of the granted port
//   ram_len_o           burst length of the granted port
//   ram_addr_o          address of the granted port
//   ram_write_data_o    write data of the granted port
//   ram_accept_i        SDRAM core accepts the current beat
//   ram_ack_i           SDRAM core completes one beat
//   ram_error_i         error qualifier for ram_ack_i
//   ram_read_data_i     read data qualifier for ram_ack_i

module sdram_pmem_arb #(
    parameter int OUTSTANDING = 4,
    parameter int OUT_W       = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [3:0]  p0_wr_i,
    input  logic        p0_rd_i,
    input  logic [7:0]  p0_len_i,
    input  logic [31:0] p0_addr_i,
    input  logic [31:0] p0_write_data_i,
    output logic        p0_accept_o,
    output logic        p0_ack_o,
    output logic        p0_error_o,
    output logic [31:0] p0_read_data_o,

    input  logic [3:0]  p1_wr_i,
    input  logic        p1_rd_i,
    input  logic [7:0]  p1_len_i,
    input  logic [31:0] p1_addr_i,
    input  logic [31:0] p1_write_data_i,
    output logic        p1_accept_o,
    output logic        p1_ack_o,
    output logic        p1_error_o,
    output logic [31:0] p1_read_data_o,

    output logic [3:0]  ram_wr_o,
    output logic        ram_rd_o,
    output logic [7:0]  ram_len_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_write_data_o,
    input  logic        ram_accept_i,
    input  logic        ram_ack_i,
    input  logic        ram_error_i,
    input  logic [31:0] ram_read_data_i
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic [OUT_W:0]   C_FULL    = (OUT_W+1)'(OUTSTANDING);
    localparam logic [OUT_W:0]   C_CNT_ONE = (OUT_W+1)'(1);
    localparam logic [OUT_W-1:0] C_PTR_ONE = OUT_W'(1);

    // Arbitration state
    state_t      r_state;
    logic        r_lock;        // port owning the current burst
    logic        r_last;        // port that won the most recent beat in IDLE
    logic [7:0]  r_beats;       // beats of the burst still to be accepted

    // In-order ID tracking FIFO: one bit per outstanding beat (0 = port0)
    logic [OUTSTANDING-1:0] r_fifo;
    logic [OUT_W-1:0]       r_wr_ptr;
    logic [OUT_W-1:0]       r_rd_ptr;
    logic [OUT_W:0]         r_count;

    logic        w_p0_req;
    logic        w_p1_req;
    logic        w_gnt_vld;
    logic        w_gnt_port;
    logic        w_not_full;
    logic        w_issue;
    logic [3:0]  w_sel_wr;
    logic        w_sel_rd;
    logic [7:0]  w_sel_len;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [3:0]  w_ram_wr;
    logic        w_ram_rd;
    logic [7:0]  w_ram_len;
    logic        w_push;
    logic        w_pop;
    logic        w_head;

    assign w_p0_req = (|p0_wr_i) | p0_rd_i;
    assign w_p1_req = (|p1_wr_i) | p1_rd_i;

    // Grant selection. Held off entirely during reset so every output is
    // quiet in the reset cycle regardless of what the requesters drive.
    always_comb begin
        w_gnt_vld  = 1'b0;
        w_gnt_port = 1'b0;
        if (!rst) begin
            if (r_state == ST_IDLE) begin
                if (w_p0_req && w_p1_req) begin
                    w_gnt_vld  = 1'b1;
                    w_gnt_port = ~r_last;
                end else if (w_p0_req) begin
                    w_gnt_vld  = 1'b1;
                    w_gnt_port = 1'b0;
                end else if (w_p1_req) begin
                    w_gnt_vld  = 1'b1;
                    w_gnt_port = 1'b1;
                end
            end else begin
                // Burst in progress: the other port is ignored entirely.
                w_gnt_port = r_lock;
                w_gnt_vld  = r_lock ? w_p1_req : w_p0_req;
            end
        end
    end

    assign w_sel_wr    = w_gnt_port ? p1_wr_i         : p0_wr_i;
    assign w_sel_rd    = w_gnt_port ? p1_rd_i         : p0_rd_i;
    assign w_sel_len   = w_gnt_port ? p1_len_i        : p0_len_i;
    assign w_sel_addr  = w_gnt_port ? p1_addr_i       : p0_addr_i;
    assign w_sel_wdata = w_gnt_port ? p1_write_data_i : p0_write_data_i;

    // A full tracking FIFO blocks issue even if an ack pops it this cycle;
    // that keeps the ack path out of the accept timing path.
    assign w_not_full = (r_count != C_FULL);
    assign w_issue    = w_gnt_vld & w_not_full;

    // A beat carrying both strobes and rd is issued as a write only.
    assign w_ram_wr  = w_issue ? w_sel_wr : 4'h0;
    assign w_ram_rd  = w_issue ? (w_sel_rd & ~(|w_sel_wr)) : 1'b0;
    assign w_ram_len = w_gnt_vld ? w_sel_len : 8'h00;

    assign ram_wr_o         = w_ram_wr;
    assign ram_rd_o         = w_ram_rd;
    assign ram_len_o        = w_ram_len;
    assign ram_addr_o       = w_gnt_vld ? w_sel_addr  : 32'h0;
    assign ram_write_data_o = w_gnt_vld ? w_sel_wdata : 32'h0;

    assign w_push = ram_accept_i & ((|w_ram_wr) | w_ram_rd);

    assign p0_accept_o = w_push & ~w_gnt_port;
    assign p1_accept_o = w_push &  w_gnt_port;

    // Completion routing. An ack with nothing outstanding (including acks of
    // beats issued before a reset) is dropped.
    assign w_head = r_fifo[r_rd_ptr];
    assign w_pop  = ram_ack_i & (r_count != '0) & ~rst;

    assign p0_ack_o       = w_pop & ~w_head;
    assign p1_ack_o       = w_pop &  w_head;
    assign p0_error_o     = w_pop & ~w_head & ram_error_i;
    assign p1_error_o     = w_pop &  w_head & ram_error_i;
    assign p0_read_data_o = w_pop ? ram_read_data_i : 32'h0;
    assign p1_read_data_o = w_pop ? ram_read_data_i : 32'h0;

    // Arbitration FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_lock  <= 1'b0;
            r_last  <= 1'b1;        // port0 wins the first contention
            r_beats <= 8'h00;
        end else if (w_push) begin
            case (r_state)
                ST_IDLE: begin
                    r_last <= w_gnt_port;
                    if (w_ram_len != 8'h00) begin
                        r_state <= ST_BURST;
                        r_lock  <= w_gnt_port;
                        r_beats <= w_ram_len;
                    end
                end
                ST_BURST: begin
                    if (r_beats <= 8'd1) begin
                        r_state <= ST_IDLE;
                        r_beats <= 8'h00;
                    end else begin
                        r_beats <= r_beats - 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ID tracking FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fifo   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_gnt_port;
                r_wr_ptr         <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_pmem_arb.sv
// tb/tb_sdram_pmem_arb.sv - scoreboard testbench for sdram_pmem_arb

module tb_sdram_pmem_arb;

    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h0000_0200;
    localparam logic [31:0] D0 = 32'h1111_1111;
    localparam logic [31:0] D1 = 32'h2222_2222;

    logic        clk;
    logic        rst;
    logic [3:0]  p0_wr_i, p1_wr_i;
    logic        p0_rd_i, p1_rd_i;
    logic [7:0]  p0_len_i, p1_len_i;
    logic [31:0] p0_addr_i, p1_addr_i;
    logic [31:0] p0_write_data_i, p1_write_data_i;
    logic        p0_accept_o, p1_accept_o;
    logic        p0_ack_o, p1_ack_o;
    logic        p0_error_o, p1_error_o;
    logic [31:0] p0_read_data_o, p1_read_data_o;
    logic [3:0]  ram_wr_o;
    logic        ram_rd_o;
    logic [7:0]  ram_len_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_write_data_o;
    logic        ram_accept_i;
    logic        ram_ack_i;
    logic        ram_error_i;
    logic [31:0] ram_read_data_i;

    sdram_pmem_arb #(.OUTSTANDING(4), .OUT_W(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .p0_wr_i          (p0_wr_i),
        .p0_rd_i          (p0_rd_i),
        .p0_len_i         (p0_len_i),
        .p0_addr_i        (p0_addr_i),
        .p0_write_data_i  (p0_write_data_i),
        .p0_accept_o      (p0_accept_o),
        .p0_ack_o         (p0_ack_o),
        .p0_error_o       (p0_error_o),
        .p0_read_data_o   (p0_read_data_o),
        .p1_wr_i          (p1_wr_i),
        .p1_rd_i          (p1_rd_i),
        .p1_len_i         (p1_len_i),
        .p1_addr_i        (p1_addr_i),
        .p1_write_data_i  (p1_write_data_i),
        .p1_accept_o      (p1_accept_o),
        .p1_ack_o         (p1_ack_o),
        .p1_error_o       (p1_error_o),
        .p1_read_data_o   (p1_read_data_o),
        .ram_wr_o         (ram_wr_o),
        .ram_rd_o         (ram_rd_o),
        .ram_len_o        (ram_len_o),
        .ram_addr_o       (ram_addr_o),
        .ram_write_data_o (ram_write_data_o),
        .ram_accept_i     (ram_accept_i),
        .ram_ack_i        (ram_ack_i),
        .ram_error_i      (ram_error_i),
        .ram_read_data_i  (ram_read_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Request codes per port: 0 idle, 1 read, 2 write (strobes 0xF), 3 write+read
    typedef struct {
        logic        rst;
        int          q0;
        logic [7:0]  l0;
        int          q1;
        logic [7:0]  l1;
        logic        acc;
        logic        ack;
        logic        err;
        logic [31:0] d;
        int          ea;    // expected accepting port, -1 none
        int          ek;    // expected acked port, -1 none
        logic [3:0]  ewr;   // expected ram_wr_o
        logic        erd;   // expected ram_rd_o
    } vec_t;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        err;
    } ack_t;

    int   tests = 0;
    int   fails = 0;
    int   vnum  = 0;
    int   acc_q[$];
    ack_t ack_q[$];

    function automatic vec_t v(input int q0, input int l0, input int q1, input int l1,
                               input int acc, input int ack, input int err,
                               input int ea, input int ek, input int ewr, input int erd,
                               input int r = 0, input logic [31:0] d = 32'h0);
        vec_t x;
        x.rst = 1'(r);   x.q0 = q0; x.l0 = 8'(l0); x.q1 = q1; x.l1 = 8'(l1);
        x.acc = 1'(acc); x.ack = 1'(ack); x.err = 1'(err); x.d = d;
        x.ea  = ea;      x.ek = ek;   x.ewr = 4'(ewr); x.erd = 1'(erd);
        return x;
    endfunction

    function automatic logic any_out();
        return p0_accept_o | p1_accept_o | p0_ack_o | p1_ack_o | p0_error_o | p1_error_o |
               (|p0_read_data_o) | (|p1_read_data_o) | (|ram_wr_o) | ram_rd_o |
               (|ram_len_o) | (|ram_addr_o) | (|ram_write_data_o);
    endfunction

    task automatic run(input vec_t x);
        ack_t a;
        rst             = x.rst;
        p0_wr_i         = (x.q0 >= 2) ? 4'hF : 4'h0;
        p0_rd_i         = (x.q0 == 1 || x.q0 == 3);
        p0_len_i        = x.l0;
        p1_wr_i         = (x.q1 >= 2) ? 4'hF : 4'h0;
        p1_rd_i         = (x.q1 == 1 || x.q1 == 3);
        p1_len_i        = x.l1;
        ram_accept_i    = x.acc;
        ram_ack_i       = x.ack;
        ram_error_i     = x.err;
        ram_read_data_i = (x.d != 32'h0) ? x.d : (32'h5A00_0000 + 32'(vnum));
        if (x.ea >= 0) acc_q.push_back(x.ea);
        if (x.ek >= 0) begin
            a.port = x.ek;
            a.data = ram_read_data_i;
            a.err  = x.err;
            ack_q.push_back(a);
        end
        #1;
        tests++;
        if (ram_wr_o !== x.ewr || ram_rd_o !== x.erd) begin
            fails++;
            $display("FAIL ram_cmd vec %0d: got wr=%h rd=%b, want wr=%h rd=%b",
                     vnum, ram_wr_o, ram_rd_o, x.ewr, x.erd);
        end
        if (x.ea >= 0) begin
            tests++;
            if (ram_len_o !== ((x.ea == 1) ? x.l1 : x.l0)) begin
                fails++;
                $display("FAIL ram_len vec %0d: got %0d, want %0d", vnum, ram_len_o,
                         (x.ea == 1) ? x.l1 : x.l0);
            end
        end
        vnum++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        p0_wr_i = 4'h0; p0_rd_i = 1'b1; p0_len_i = 8'd3;
        p1_wr_i = 4'hF; p1_rd_i = 1'b0; p1_len_i = 8'd0;
        ram_accept_i = 1'b1; ram_ack_i = 1'b1; ram_error_i = 1'b1;
        ram_read_data_i = 32'hFFFF_FFFF;
        #1;
        tests++;
        if (any_out()) begin
            fails++;
            $display("FAIL reset_cycle_outputs: got some output=1, want all 0");
        end
        @(posedge clk); #1;
        rst = 1'b0;
        p0_rd_i = 1'b0; p1_wr_i = 4'h0; p0_len_i = 8'd0;
        ram_ack_i = 1'b0; ram_error_i = 1'b0; ram_read_data_i = 32'h0;
        #1;
        tests++;
        if (any_out()) begin
            fails++;
            $display("FAIL post_reset_outputs: got some output=1, want all 0");
        end
        @(posedge clk); #1;
    endtask

    task automatic end_test(input string name);
        tests++;
        if (acc_q.size() != 0 || ack_q.size() != 0) begin
            fails++;
            $display("FAIL %s drain: got %0d accepts and %0d acks still expected, want 0 and 0",
                     name, acc_q.size(), ack_q.size());
        end
        acc_q.delete();
        ack_q.delete();
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an accept or ack.
    always @(negedge clk) begin
        int   e;
        int   g;
        ack_t a;
        if (p0_accept_o || p1_accept_o) begin
            tests++;
            g = p1_accept_o ? 1 : 0;
            if (p0_accept_o && p1_accept_o) begin
                fails++;
                $display("FAIL accept_both: got both accepts, want one");
            end else if (acc_q.size() == 0) begin
                fails++;
                $display("FAIL accept_unexpected: got accept port %0d, want none", g);
            end else begin
                e = acc_q.pop_front();
                if (g != e || ram_addr_o !== ((e == 1) ? A1 : A0) ||
                    ram_write_data_o !== ((e == 1) ? D1 : D0)) begin
                    fails++;
                    $display("FAIL accept_port: got port %0d addr %h wdata %h, want port %0d addr %h wdata %h",
                             g, ram_addr_o, ram_write_data_o, e,
                             (e == 1) ? A1 : A0, (e == 1) ? D1 : D0);
                end
            end
        end
        if (p0_ack_o || p1_ack_o || p0_error_o || p1_error_o) begin
            tests++;
            g = p1_ack_o ? 1 : 0;
            if ((p0_ack_o && p1_ack_o) || (p0_error_o && !p0_ack_o) || (p1_error_o && !p1_ack_o)) begin
                fails++;
                $display("FAIL ack_qual: got ack %b%b err %b%b, want one ack with its own error",
                         p1_ack_o, p0_ack_o, p1_error_o, p0_error_o);
            end else if (ack_q.size() == 0) begin
                fails++;
                $display("FAIL ack_unexpected: got ack port %0d, want none", g);
            end else begin
                a = ack_q.pop_front();
                if (g != a.port ||
                    ((g == 1) ? p1_read_data_o : p0_read_data_o) !== a.data ||
                    ((g == 1) ? p1_error_o : p0_error_o) !== a.err) begin
                    fails++;
                    $display("FAIL ack_route: got port %0d data %h err %b, want port %0d data %h err %b",
                             g, (g == 1) ? p1_read_data_o : p0_read_data_o,
                             (g == 1) ? p1_error_o : p0_error_o, a.port, a.data, a.err);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        p0_wr_i = 4'h0; p0_rd_i = 1'b0; p0_len_i = 8'h0;
        p1_wr_i = 4'h0; p1_rd_i = 1'b0; p1_len_i = 8'h0;
        p0_addr_i = A0; p0_write_data_i = D0;
        p1_addr_i = A1; p1_write_data_i = D1;
        ram_accept_i = 1'b0; ram_ack_i = 1'b0; ram_error_i = 1'b0;
        ram_read_data_i = 32'h0;
        @(posedge clk); #1;

        // 1: single read, ack three cycles later
        do_reset();
        run(v(1,0,0,0, 1,0,0,  0,-1, 0,1));
        run(v(0,0,0,0, 1,0,0, -1,-1, 0,0));
        run(v(0,0,0,0, 1,0,0, -1,-1, 0,0));
        run(v(0,0,0,0, 1,1,0, -1, 0, 0,0, 0, 32'hDEAD_BEEF));
        end_test("single_read");

        // 2: both ports single beats, alternating grants, acks keeping pace
        do_reset();
        run(v(1,0,1,0, 1,0,0,  0,-1, 0,1));
        run(v(1,0,1,0, 1,1,0,  1, 0, 0,1));
        run(v(1,0,1,0, 1,1,0,  0, 1, 0,1));
        run(v(1,0,1,0, 1,1,1,  1, 0, 0,1));
        run(v(1,0,1,0, 1,1,0,  0, 1, 0,1));
        run(v(1,0,1,0, 1,1,0,  1, 0, 0,1));
        run(v(0,0,0,0, 1,1,0, -1, 1, 0,0));
        end_test("round_robin");

        // 3: p1 write burst (wr+rd issued as write) locks out p0 reads
        run(v(1,0,0,0, 1,0,0,  0,-1, 0,1));
        for (int i = 0; i < 4; i++)
            run(v(1,0,3,3, 1,1,0, 1, (i == 0) ? 0 : 1, 15,0));
        run(v(1,0,1,0, 1,1,0,  0, 1, 0,1));
        run(v(0,0,1,0, 1,1,0,  1, 0, 0,1));
        run(v(0,0,0,0, 1,1,0, -1, 1, 0,0));
        end_test("burst_lock");

        // 4: tracking FIFO full with acks held off
        do_reset();
        for (int i = 0; i < 4; i++)
            run(v(1,0,1,0, 1,0,0, i % 2,-1, 0,1));
        run(v(1,0,1,0, 1,0,0, -1,-1, 0,0));
        run(v(1,0,1,0, 1,0,0, -1,-1, 0,0));
        run(v(1,0,1,0, 1,1,0, -1, 0, 0,0));
        run(v(1,0,1,0, 1,0,0,  0,-1, 0,1));
        for (int i = 0; i < 4; i++)
            run(v(0,0,0,0, 1,1,0, -1, (i % 2 == 0) ? 1 : 0, 0,0));
        end_test("fifo_full");

        // 5: accept stall mid-burst, p1 requesting throughout
        do_reset();
        run(v(1,7,1,0, 1,0,0,  0,-1, 0,1));
        run(v(1,7,1,0, 1,1,0,  0, 0, 0,1));
        run(v(1,7,1,0, 1,1,0,  0, 0, 0,1));
        run(v(1,7,1,0, 0,1,0, -1, 0, 0,1));
        for (int i = 0; i < 4; i++)
            run(v(1,7,1,0, 0,0,0, -1,-1, 0,1));
        run(v(1,7,1,0, 1,0,0,  0,-1, 0,1));
        for (int i = 0; i < 4; i++)
            run(v(1,7,1,0, 1,1,0, 0, 0, 0,1));
        run(v(0,0,1,0, 1,1,0,  1, 0, 0,1));
        run(v(0,0,0,0, 1,1,0, -1, 1, 0,0));
        end_test("accept_stall");

        // 6: reset mid-burst, stale acks dropped, port0 wins next contention
        do_reset();
        run(v(1,7,1,0, 1,0,0,  0,-1, 0,1));
        run(v(1,7,1,0, 1,0,0,  0,-1, 0,1));
        run(v(1,7,1,0, 1,1,0, -1,-1, 0,0, 1));
        run(v(1,0,1,0, 1,1,0,  0,-1, 0,1));
        run(v(0,0,1,0, 1,1,0,  1, 0, 0,1));
        run(v(0,0,0,0, 1,1,0, -1, 1, 0,0));
        run(v(0,0,0,0, 1,1,0, -1,-1, 0,0));
        end_test("reset_mid_burst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
